// File: rtl/fetch_queue_pkg.sv
// Constants and entry layout shared by fetch, the fetch queue and decode.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR  = 32'h0;
  localparam int          IF_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue of {pc, instr}; push visible at head one edge later, no bypass.
// Backpressure: in_ready drops when full (no pass-through even with a pop); flush empties at next edge.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  if_entry_t        mem [DEPTH];
  if_entry_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != (PTR_W+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Redirect: wrong-path entries and any concurrent push/pop are dropped.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head.pc    : 32'h0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/full, drain order, streaming wrap, flush, async reset.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive_push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    reset = 1'b1;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    tests++; if (out_instr !== NOP_INSTR) begin fails++; $display("FAIL reset_out_instr: got %h want %h", out_instr, NOP_INSTR); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(RESET_PC + 32'(4*i));
      step();
      tests++; if (count !== 3'(i+1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i+1); end
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    drive_push(32'h3010);
    step();
    in_valid = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_overflow_count: got %0d want 4", count); end
    tests++; if (out_pc !== 32'h3000) begin fails++; $display("FAIL fill_head_pc: got %h want 00003000", out_pc); end
    tests++; if (out_instr !== 32'hC0DE3000) begin fails++; $display("FAIL fill_head_instr: got %h want c0de3000", out_instr); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_pc !== 32'h3000 + 32'(4*i)) begin fails++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, 32'h3000 + 32'(4*i)); end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty_valid: got %b want 0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL drain_empty_count: got %0d want 0", count); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL drain_empty_pc: got %h want 0", out_pc); end
  endtask

  task automatic test_stream_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h3000 + 32'(4*i));
      step();
      tests++; if (count !== 3'd1) begin fails++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
      tests++; if (out_pc !== 32'h3000 + 32'(4*i)) begin fails++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'h3000 + 32'(4*i)); end
      tests++; if (out_instr !== instr_of(32'h3000 + 32'(4*i))) begin fails++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, instr_of(32'h3000 + 32'(4*i))); end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL stream_final_count: got %0d want 0", count); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h3200 + 32'(4*i));
      step();
    end
    // Full with a pop: the pop happens, the push must not.
    drive_push(32'h3300);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_pop_count: got %0d want 3", count); end
    tests++; if (out_pc !== 32'h3204) begin fails++; $display("FAIL full_pop_head: got %h want 00003204", out_pc); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
    step(); step();
    tests++; if (out_pc !== 32'h320c) begin fails++; $display("FAIL full_pop_last: got %h want 0000320c", out_pc); end
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL full_pop_drained: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h3100 + 32'(4*i));
      step();
    end
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    flush = 1'b1;
    drive_push(32'h3040);
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL flush_out_pc: got %h want 0", out_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b0 || out_pc === 32'h3040) begin fails++; $display("FAIL flush_leak[%0d]: got valid=%b pc=%h want valid=0", i, out_valid, out_pc); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_push(32'h3400 + 32'(4*i));
      step();
    end
    in_valid = 1'b0;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL areset_pre_count: got %0d want 2", count); end
    #2 reset = 1'b0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    #1 reset = 1'b1;
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL areset_after_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
